instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Per-core instruction fetch unit. It is the producer side of the core's instruction path and supplies the 16-bit `instruction` word that the per-core decoder latches during DECODE. When the core scheduler enters FETCH, the block issues a read to program memory over a valid/ready handshake, or serves the word from a small direct-mapped instruction cache. It then reports completion through `fetcher_state`, and the scheduler advances to DECODE on that report.

## Interface
Parameters:
- `PROGRAM_MEM_ADDR_BITS`, 8, width of the PC and of the program memory address.
- `PROGRAM_MEM_DATA_BITS`, 16, instruction width.
- `CACHE_LINES`, 4, number of cache entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `core_state`  in  3  scheduler state; FETCH=3'b001, DECODE=3'b010.
- `current_pc`  in  `PROGRAM_MEM_ADDR_BITS`  address of the instruction to fetch.
- `cache_invalidate`  in  1  clears all cache valid bits.
- `mem_read_valid`  out  1  program-memory read request.
- `mem_read_address`  out  `PROGRAM_MEM_ADDR_BITS`  request address.
- `mem_read_ready`  in  1  memory response strobe.
- `mem_read_data`  in  `PROGRAM_MEM_DATA_BITS`  response data, valid when `mem_read_ready`=1.
- `fetcher_state`  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
- `instruction`  out  `PROGRAM_MEM_DATA_BITS`  fetched word, registered.

## Operation
- **Cache geometry:**
  - index = `current_pc[log2(CACHE_LINES)-1:0]`.
  - tag = remaining upper PC bits.
  - Per line: valid bit, tag, data.
- **IDLE:** when `core_state`==FETCH is sampled:
  - Hit (line valid and tag matches): `instruction`<=line data, go to FETCHED, no memory request.
  - Miss: `mem_read_valid`<=1, `mem_read_address`<=`current_pc`, go to FETCHING.
- **FETCHING:**
  - `mem_read_valid` and `mem_read_address` are held constant until `mem_read_ready` is sampled high.
  - On that edge: `mem_read_valid`<=0, `instruction`<=`mem_read_data`, the indexed line is filled (valid=1, tag, data), go to FETCHED.
- **FETCHED:**
  - `instruction` is held stable.
  - Go to IDLE when `core_state`==DECODE is sampled.
  - `instruction` keeps its value until the next capture.
- States 3'b011–3'b111 are unreachable. If entered, they return to IDLE on the next edge.
- **Boundary rules:**
  - `mem_read_ready` while `mem_read_valid`=0 is ignored.
  - `core_state` leaving FETCH during FETCHING does not abort the request. The read completes and the state goes to FETCHED.
  - FETCH held across FETCHED does not start a second fetch; only DECODE releases the state.
  - `cache_invalidate` clears every valid bit on the next edge. A fill on the same edge is discarded; the word is still delivered to `instruction`.
  - `cache_invalidate` during an IDLE lookup on the same edge forces a miss.
- **Reset:**
  - `fetcher_state`=IDLE, `mem_read_valid`=0, `mem_read_address`=0, `instruction`=0, all cache valid bits=0.
  - Reset during FETCHING drops `mem_read_valid` on that edge. A late `mem_read_ready` is then ignored.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Hit:** FETCH sampled at edge N → `fetcher_state`=FETCHED and `instruction` valid after N (1 cycle).
- **Miss:**
  - FETCH sampled at edge N → `mem_read_valid`=1 after N.
  - `mem_read_ready` sampled at edge M>N → FETCHED and data after M.
  - Latency is M−N+1 cycles minimum 2.
- DECODE sampled at edge D → IDLE after D. A new fetch can begin at edge D+1.
- The decoder latches `instruction` during DECODE, so the value must be stable from FETCHED through edge D.

## Configuration
- Macro: `INSTRUCTION_FETCHER_CACHE_EN`.
- **Defined:** the cache is instantiated as described. Hits complete in 1 cycle with no memory traffic.
- **Undefined:**
  - No cache storage exists and every fetch is a miss.
  - `cache_invalidate` is ignored.
  - `CACHE_LINES` is unused.
  - Handshake and state behaviour are otherwise identical.

## Test plan
1. Reset, `current_pc`=0x05, FETCH; `mem_read_ready` with data 0x3123 three cycles after `mem_read_valid` rises → valid high 3 cycles with address 0x05, `instruction`=0x3123, FETCHED; DECODE → IDLE next edge.
2. Cache enabled, refetch PC 0x05 → FETCHED one cycle after FETCH, `mem_read_valid` never rises, `instruction`=0x3123.
3. `CACHE_LINES`=4: fetch 0x01 (data 0x9A07), then 0x05 (data 0x3123), then 0x01 again → the third fetch misses and re-reads memory, returning 0x9A07.
4. Fill 0x05, pulse `cache_invalidate`, fetch 0x05 → miss with memory request at 0x05. A second run asserts invalidate on the fill edge → the word is delivered but the next fetch of 0x05 misses.
5. Reset asserted while FETCHING → `mem_read_valid`=0 and IDLE after that edge; `mem_read_ready` pulsed afterward leaves `instruction`=0.
6. Macro undefined: three consecutive fetches of 0x05 → three memory requests, each FETCHED only after `mem_read_ready`.

Source files
------------

// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: fetches one 16-bit word per FETCH request, from cache or program memory.
// Latency: cache hit 1 cycle; miss 1 cycle to request, then 1 cycle after mem_read_ready is sampled.
// Backpressure: the request is held until mem_read_ready; FETCHED is held until core_state==DECODE.
// Optional cache: define INSTRUCTION_FETCHER_CACHE_EN to build the direct-mapped instruction cache.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } fetch_state_e;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  fetch_state_e                     state_q, state_d;
  logic                             mem_read_valid_q, mem_read_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instruction_q, instruction_d;

  // Cache lookup result for the current PC, and the strobe that writes a returned word into it.
  logic                             lookup_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_data;
  logic                             fill_en;

  // Next-state and output computation for the fetch handshake.
  always_comb begin
    state_d            = state_q;
    mem_read_valid_d   = mem_read_valid_q;
    mem_read_address_d = mem_read_address_q;
    instruction_d      = instruction_q;
    fill_en            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (lookup_hit) begin
            instruction_d = lookup_data;
            state_d       = ST_FETCHED;
          end else begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = current_pc;
            state_d            = ST_FETCHING;
          end
        end
      end
      ST_FETCHING: begin
        // The request is never aborted by core_state; only the memory response ends it.
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          instruction_d    = mem_read_data;
          fill_en          = 1'b1;
          state_d          = ST_FETCHED;
        end
      end
      ST_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        mem_read_valid_d = 1'b0;
      end
    endcase
  end

  // Handshake and instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      mem_read_valid_q   <= 1'b0;
      mem_read_address_q <= '0;
      instruction_q      <= '0;
    end else begin
      state_q            <= state_d;
      mem_read_valid_q   <= mem_read_valid_d;
      mem_read_address_q <= mem_read_address_d;
      instruction_q      <= instruction_d;
    end
  end

`ifdef INSTRUCTION_FETCHER_CACHE_EN
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  logic [CACHE_LINES-1:0]           line_valid_q, line_valid_d;
  logic [TAG_BITS-1:0]              line_tag_q  [CACHE_LINES];
  logic [TAG_BITS-1:0]              line_tag_d  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data_q [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] line_data_d [CACHE_LINES];

  logic [IDX_BITS-1:0] lookup_idx, fill_idx;
  logic [TAG_BITS-1:0] lookup_tag, fill_tag;

  assign lookup_idx = current_pc[IDX_BITS-1:0];
  assign lookup_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  // The fill uses the held request address, since current_pc may move while the read is outstanding.
  assign fill_idx   = mem_read_address_q[IDX_BITS-1:0];
  assign fill_tag   = mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

  // An invalidate on the lookup edge turns a would-be hit into a miss.
  assign lookup_hit  = line_valid_q[lookup_idx] && (line_tag_q[lookup_idx] == lookup_tag)
                       && !cache_invalidate;
  assign lookup_data = line_data_q[lookup_idx];

  // Line update: fill on memory return, then invalidate wins over a same-edge fill.
  always_comb begin
    line_valid_d = line_valid_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    if (fill_en) begin
      line_valid_d[fill_idx] = 1'b1;
      line_tag_d[fill_idx]   = fill_tag;
      line_data_d[fill_idx]  = mem_read_data;
    end
    if (cache_invalidate) begin
      line_valid_d = '0;
    end
  end

  // Valid bits are reset; tag and data are qualified by valid and need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_q <= '0;
    end else begin
      line_valid_q <= line_valid_d;
    end
  end

  // Tag and data storage.
  always_ff @(posedge clk) begin
    line_tag_q  <= line_tag_d;
    line_data_q <= line_data_d;
  end
`else
  // Without the cache every fetch goes to memory; the cache controls have no effect.
  logic unused_cache;
  assign lookup_hit   = 1'b0;
  assign lookup_data  = '0;
  assign unused_cache = cache_invalidate | fill_en | (CACHE_LINES < 2);
`endif

  assign fetcher_state    = state_q;
  assign mem_read_valid   = mem_read_valid_q;
  assign mem_read_address = mem_read_address_q;
  assign instruction      = instruction_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed scenarios then randomized fetches against a reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs are changed at the same point.
// The model tracks cache contents with plain arrays indexed by pc % lines and tagged by pc / lines.
module tb_instruction_fetcher;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CL = 4;
`ifdef INSTRUCTION_FETCHER_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  localparam logic [2:0] FETCH  = 3'b001;
  localparam logic [2:0] DECODE = 3'b010;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          cache_invalidate;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [256];
  bit            m_valid [CL];
  int            m_tag   [CL];
  logic [DW-1:0] m_data  [CL];

  always #5 clk = ~clk;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW),
    .CACHE_LINES(CL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_state(core_state),
    .current_pc(current_pc),
    .cache_invalidate(cache_invalidate),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < CL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_state = 3'b000;
    cache_invalidate = 1'b0;
    mem_read_ready = 1'b0;
    step();
    reset = 1'b0;
    model_clear();
    chk("reset_state", 32'(fetcher_state), 32'd0);
    chk("reset_valid", 32'(mem_read_valid), 32'd0);
    chk("reset_addr", 32'(mem_read_address), 32'd0);
    chk("reset_instr", 32'(instruction), 32'd0);
  endtask

  task automatic pulse_invalidate();
    cache_invalidate = 1'b1;
    step();
    cache_invalidate = 1'b0;
    model_clear();
  endtask

  // One full FETCH..DECODE transaction. lat = cycles mem_read_valid stays high on a miss.
  task automatic fetch(input logic [AW-1:0] pc, input int lat, input bit inv_lookup,
                       input bit inv_fill, input int hold);
    int idx;
    bit hit;
    logic [DW-1:0] exp_instr;
    logic [2:0] wander [3];
    wander[0] = 3'b000; wander[1] = FETCH; wander[2] = 3'b100;
    idx = int'(pc) % CL;
    hit = CACHE_EN && !inv_lookup && m_valid[idx] && (m_tag[idx] == int'(pc) / CL);
    core_state = FETCH;
    current_pc = pc;
    cache_invalidate = inv_lookup;
    mem_read_ready = 1'b0;
    step();
    cache_invalidate = 1'b0;
    if (inv_lookup) model_clear();
    if (hit) begin
      exp_instr = m_data[idx];
      chk("hit_state", 32'(fetcher_state), 32'd2);
      chk("hit_no_req", 32'(mem_read_valid), 32'd0);
      chk("hit_instr", 32'(instruction), 32'(exp_instr));
    end else begin
      exp_instr = mem[pc];
      chk("req_valid", 32'(mem_read_valid), 32'd1);
      chk("req_addr", 32'(mem_read_address), 32'(pc));
      chk("req_state", 32'(fetcher_state), 32'd1);
      for (int i = 1; i < lat; i++) begin
        current_pc = AW'($urandom);
        mem_read_data = DW'($urandom);
        core_state = wander[$urandom_range(0, 2)];
        step();
        chk("wait_valid", 32'(mem_read_valid), 32'd1);
        chk("wait_addr", 32'(mem_read_address), 32'(pc));
        chk("wait_state", 32'(fetcher_state), 32'd1);
      end
      mem_read_ready = 1'b1;
      mem_read_data = mem[pc];
      cache_invalidate = inv_fill;
      step();
      mem_read_ready = 1'b0;
      cache_invalidate = 1'b0;
      mem_read_data = DW'($urandom);
      chk("resp_state", 32'(fetcher_state), 32'd2);
      chk("resp_valid", 32'(mem_read_valid), 32'd0);
      chk("resp_instr", 32'(instruction), 32'(exp_instr));
      if (inv_fill) begin
        model_clear();
      end else begin
        m_valid[idx] = 1'b1;
        m_tag[idx] = int'(pc) / CL;
        m_data[idx] = mem[pc];
      end
    end
    for (int i = 0; i < hold; i++) begin
      core_state = FETCH;
      mem_read_ready = 1'($urandom_range(0, 1));
      step();
      mem_read_ready = 1'b0;
      chk("hold_state", 32'(fetcher_state), 32'd2);
      chk("hold_valid", 32'(mem_read_valid), 32'd0);
      chk("hold_instr", 32'(instruction), 32'(exp_instr));
    end
    core_state = DECODE;
    step();
    core_state = 3'b000;
    chk("decode_state", 32'(fetcher_state), 32'd0);
    chk("decode_instr", 32'(instruction), 32'(exp_instr));
    chk("decode_valid", 32'(mem_read_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1;
    core_state = 3'b000;
    current_pc = '0;
    cache_invalidate = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h05] = 16'h3123;
    mem[8'h01] = 16'h9A07;
    model_clear();

    // Basic miss with three-cycle memory latency, then DECODE release.
    do_reset();
    fetch(8'h05, 3, 1'b0, 1'b0, 0);
    // Refetch of the same PC (hit when the cache is built).
    fetch(8'h05, 2, 1'b0, 1'b0, 2);
    // Conflicting PCs on the same line evict each other.
    fetch(8'h01, 2, 1'b0, 1'b0, 0);
    fetch(8'h05, 1, 1'b0, 1'b0, 0);
    fetch(8'h01, 2, 1'b0, 1'b0, 1);
    // Invalidate pulse, invalidate on the fill edge, invalidate on the lookup edge.
    fetch(8'h05, 1, 1'b0, 1'b0, 0);
    pulse_invalidate();
    fetch(8'h05, 2, 1'b0, 1'b0, 0);
    fetch(8'h05, 2, 1'b0, 1'b1, 0);
    fetch(8'h05, 1, 1'b0, 1'b0, 0);
    fetch(8'h05, 2, 1'b1, 1'b0, 0);
    fetch(8'h05, 1, 1'b0, 1'b0, 0);

    // Reset while a request is outstanding; a late response must be ignored.
    core_state = FETCH;
    current_pc = 8'h07;
    step();
    chk("rst_pre_valid", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    core_state = 3'b000;
    step();
    reset = 1'b0;
    model_clear();
    chk("rst_mid_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_mid_state", 32'(fetcher_state), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data = 16'hBEEF;
    step();
    mem_read_ready = 1'b0;
    chk("late_ready_instr", 32'(instruction), 32'd0);
    chk("late_ready_state", 32'(fetcher_state), 32'd0);
    chk("late_ready_valid", 32'(mem_read_valid), 32'd0);

    // Three consecutive fetches of one PC.
    for (int i = 0; i < 3; i++) fetch(8'h05, 2, 1'b0, 1'b0, 0);

    // Randomized transactions over a small PC range so hits and conflicts both occur.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) pulse_invalidate();
      fetch(AW'($urandom_range(0, 11)), $urandom_range(1, 4),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
